// File: rtl/wallace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wallace_pkg : states and nibble step tables for the 8x8 sequenced multiply |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package wallace_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NSTEPS = 4;

   function automatic logic [3:0] step_shift(input logic [1:0] step);
      logic [3:0] s;
      case (step)
         2'd0:    s = 4'd0;
         2'd1:    s = 4'd4;
         2'd2:    s = 4'd4;
         default: s = 4'd8;
      endcase
      return s;
   endfunction

   // Returns {a nibble, b nibble} for the given step.
   function automatic logic [7:0] step_nibbles(input logic [1:0] step,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
      logic [7:0] n;
      case (step)
         2'd0:    n = {a[3:0], b[3:0]};
         2'd1:    n = {a[7:4], b[3:0]};
         2'd2:    n = {a[3:0], b[7:4]};
         default: n = {a[7:4], b[7:4]};
      endcase
      return n;
   endfunction

endpackage : wallace_pkg
`default_nettype wire

// File: rtl/wallace8_seq_ctrl_wallace.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Wallace : combinational 4x4 unsigned multiplier, carry-save row reduction  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module Wallace (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   logic [7:0] w_r0, w_r1, w_r2, w_r3;
   logic [7:0] w_s1, w_c1, w_s2, w_c2;

   assign w_r0 = {4'd0, a & {4{b[0]}}};
   assign w_r1 = {3'd0, a & {4{b[1]}}, 1'b0};
   assign w_r2 = {2'd0, a & {4{b[2]}}, 2'b0};
   assign w_r3 = {1'd0, a & {4{b[3]}}, 3'b0};

   // Two 3:2 compressor layers, then one carry-propagate add.
   assign w_s1 = w_r0 ^ w_r1 ^ w_r2;
   assign w_c1 = {((w_r0[6:0] & w_r1[6:0]) | (w_r0[6:0] & w_r2[6:0]) | (w_r1[6:0] & w_r2[6:0])), 1'b0};
   assign w_s2 = w_s1 ^ w_c1 ^ w_r3;
   assign w_c2 = {((w_s1[6:0] & w_c1[6:0]) | (w_s1[6:0] & w_r3[6:0]) | (w_c1[6:0] & w_r3[6:0])), 1'b0};
   assign p    = w_s2 + w_c2;

endmodule : Wallace
`default_nettype wire

// File: rtl/wallace8_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wallace8_seq_ctrl : 8x8 -> 16 multiply over four passes of one 4x4 Wallace |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module wallace8_seq_ctrl
   import wallace_pkg::*;
#(
   parameter bit PIPE_PP = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);
   state_t      r_state;
   logic [1:0]  r_step;
   logic [7:0]  r_a, r_b;
   logic [15:0] r_acc, r_pp, r_product;
   logic        r_ready, r_busy, r_done;

   logic [7:0]  w_nib;
   logic [3:0]  w_wa, w_wb;
   logic [7:0]  w_pp;
   logic [15:0] w_term, w_addend, w_acc_next;
   logic        w_add_en, w_last;

   assign w_nib = step_nibbles(r_step, r_a, r_b);
   assign w_wa  = (r_state == MUL) ? w_nib[7:4] : 4'd0;
   assign w_wb  = (r_state == MUL) ? w_nib[3:0] : 4'd0;

   Wallace u_wallace (
      .a (w_wa),
      .b (w_wb),
      .p (w_pp)
   );

   assign w_term = {8'd0, w_pp} << step_shift(r_step);
   assign w_last = (r_step == 2'(NSTEPS - 1));

   // With the pp register, step 0 has nothing valid yet and DRAIN adds the last term.
   assign w_addend   = PIPE_PP ? r_pp : w_term;
   assign w_add_en   = PIPE_PP ? (((r_state == MUL) && (r_step != 2'd0)) || (r_state == DRAIN))
                               : (r_state == MUL);
   assign w_acc_next = r_acc + (w_add_en ? w_addend : 16'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_step    <= 2'd0;
         r_a       <= 8'd0;
         r_b       <= 8'd0;
         r_acc     <= 16'd0;
         r_pp      <= 16'd0;
         r_product <= 16'd0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_pp   <= w_term;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= 16'd0;
                  r_step  <= 2'd0;
                  r_state <= MUL;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            MUL: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= w_acc_next;
                  if (!w_last) begin
                     r_step <= r_step + 2'd1;
                  end else if (PIPE_PP) begin
                     r_state <= DRAIN;
                  end else begin
                     r_state   <= DONE;
                     r_product <= w_acc_next;
                     r_done    <= 1'b1;
                     r_ready   <= 1'b1;
                     r_busy    <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               if (abort) begin
                  r_state <= IDLE;
               end else begin
                  r_acc     <= w_acc_next;
                  r_product <= w_acc_next;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready   = r_ready;
   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule : wallace8_seq_ctrl
`default_nettype wire

// File: tb/tb_wallace8_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wallace8_seq_ctrl : directed and random checks, both PIPE_PP settings   |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_wallace8_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start0, abort0, start1, abort1;
   logic [7:0]  a0, b0, a1, b1;
   logic        ready0, busy0, done0, ready1, busy1, done1;
   logic [15:0] product0, product1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wallace8_seq_ctrl #(.PIPE_PP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .a(a0), .b(b0),
      .ready(ready0), .busy(busy0), .done(done0), .product(product0));

   wallace8_seq_ctrl #(.PIPE_PP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .a(a1), .b(b1),
      .ready(ready1), .busy(busy1), .done(done1), .product(product1));

   task automatic drive(input bit sel, input logic st, input logic ab,
                        input logic [7:0] av, input logic [7:0] bv);
      if (sel) begin start1 = st; abort1 = ab; a1 = av; b1 = bv; end
      else     begin start0 = st; abort0 = ab; a0 = av; b0 = bv; end
   endtask

   function automatic logic get_done(input bit sel);
      return sel ? done1 : done0;
   endfunction

   // Called #1 after a rising edge; returns edges from accept until done is seen.
   task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output logic [15:0] prod);
      drive(sel, 1'b1, 1'b0, av, bv);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 8'd0, 8'd0);
      lat = 1;
      while (!get_done(sel) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      prod = sel ? product1 : product0;
   endtask

   task automatic test_reset();
      total++;
      if ({ready0, busy0, done0, product0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL reset_dut0: got rdy=%b busy=%b done=%b prod=%h want 1 0 0 0000",
                  ready0, busy0, done0, product0);
      end
      total++;
      if ({ready1, busy1, done1, product1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL reset_dut1: got rdy=%b busy=%b done=%b prod=%h want 1 0 0 0000",
                  ready1, busy1, done1, product1);
      end
   endtask

   task automatic test_max();
      drive(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (k == 0) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         total++;
         if ({ready0, busy0, done0} !== 3'b010) begin
            bad++;
            $display("FAIL max_busy_cycle%0d: got rdy/busy/done=%b%b%b want 010", k + 1, ready0, busy0, done0);
         end
      end
      @(posedge clk); #1;
      total++;
      if ({done0, ready0, product0} !== {1'b1, 1'b1, 16'hFE01}) begin
         bad++;
         $display("FAIL max_done: got done=%b rdy=%b prod=%h want 1 1 fe01", done0, ready0, product0);
      end
      @(posedge clk); #1;
      total++;
      if ({done0, ready0} !== 2'b01) begin
         bad++;
         $display("FAIL max_pulse: got done=%b rdy=%b want 0 1", done0, ready0);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [15:0] p;
      run_op(1'b0, 8'h12, 8'h34, lat, p);
      total++;
      if (lat != 5 || p !== 16'h03A8) begin
         bad++;
         $display("FAIL b2b_first: got lat=%0d prod=%h want 5 03a8", lat, p);
      end
      // Start and abort together in the DONE cycle: start must win.
      drive(1'b0, 1'b1, 1'b1, 8'h0F, 8'h10);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      total++;
      if ({busy0, done0} !== 2'b10) begin
         bad++;
         $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy0, done0);
      end
      lat = 1;
      while (!done0 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat != 5 || product0 !== 16'h00F0) begin
         bad++;
         $display("FAIL b2b_second: got lat=%0d prod=%h want 5 00f0", lat, product0);
      end
   endtask

   task automatic test_start_busy();
      int lat;
      logic quiet;
      drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (busy0) drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
         else       drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      end while (!done0 && lat < 20);
      total++;
      if (lat != 5 || product0 !== 16'h03A8) begin
         bad++;
         $display("FAIL start_busy: got lat=%0d prod=%h want 5 03a8", lat, product0);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      quiet = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         if (done0 !== 1'b0 || ready0 !== 1'b1) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("FAIL start_busy_idle: got quiet=%b want 1", quiet);
      end
   endtask

   task automatic test_abort();
      logic quiet;
      drive(1'b0, 1'b1, 1'b0, 8'hAB, 8'hCD);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      total++;
      if ({ready0, busy0, done0, product0} !== {1'b1, 1'b0, 1'b0, 16'h03A8}) begin
         bad++;
         $display("FAIL abort: got rdy=%b busy=%b done=%b prod=%h want 1 0 0 03a8",
                  ready0, busy0, done0, product0);
      end
      quiet = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (done0 !== 1'b0 || product0 !== 16'h03A8) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("FAIL abort_quiet: got quiet=%b want 1", quiet);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if ({ready0, busy0, done0, product0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL reset_mid: got rdy=%b busy=%b done=%b prod=%h want 1 0 0 0000",
                  ready0, busy0, done0, product0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_pipe();
      int lat;
      logic [15:0] p;
      run_op(1'b1, 8'h80, 8'h02, lat, p);
      total++;
      if (lat != 6 || p !== 16'h0100) begin
         bad++;
         $display("FAIL pipe_basic: got lat=%0d prod=%h want 6 0100", lat, p);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random(input bit sel);
      int lat;
      logic [15:0] p;
      logic [7:0]  av, bv;
      for (int i = 0; i < 1000; i++) begin
         av = 8'($urandom);
         bv = 8'($urandom);
         run_op(sel, av, bv, lat, p);
         total++;
         if (lat != (sel ? 6 : 5) || p !== 16'(av) * 16'(bv)) begin
            bad++;
            $display("FAIL random_pipe%0d: %h*%h got lat=%0d prod=%h want lat=%0d prod=%h",
                     sel, av, bv, lat, p, (sel ? 6 : 5), 16'(av) * 16'(bv));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_max();
      test_back_to_back();
      test_start_busy();
      test_abort();
      test_reset_mid();
      test_pipe();
      test_random(1'b0);
      test_random(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wallace8_seq_ctrl
`default_nettype wire
